ram_line_buffer_multi_tap: RTL and testbench

//  RAM-based multi-tap line buffer for the convolution datapath. Takes one feature word per accepted

---
 rtl/ram_line_buffer_multi_tap.sv | 160 ++++++++++++++++
 tb/tb_ram_line_buffer_multi_tap.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_line_buffer_multi_tap.sv
// RAM-based multi-tap line buffer: current word plus TAPS copies delayed by k*L accepted beats.
// Define LINE_BUF_ZERO_FILL_EN to force not-yet-filled taps to zero (top-edge padding).
module ram_line_buffer_multi_tap #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int TAPS   = 2
) (
    input  logic                       system_clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [ADDR_W-1:0]          shift_size,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    output logic [DATA_W*(TAPS+1)-1:0] out_data,
    output logic                       primed
);

    localparam int FILL_W = ADDR_W + 3;
    localparam int OUT_W  = DATA_W * (TAPS + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = '1;

    logic                     accept;
    logic                     load_pending_q;
    logic [ADDR_W-1:0]        len_q, len_d, len_eff, shift_clamped;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_addr;
    logic [FILL_W-1:0]        fill_q, fill_d, prime_thresh;
    logic                     s1_valid_q, s1_primed_q;
    logic [ADDR_W-1:0]        s1_addr_q;
    logic [DATA_W-1:0]        s1_data_q;
    logic [TAPS*DATA_W-1:0]   rd_all;
    logic [OUT_W-1:0]         out_d, out_data_q;
    logic                     out_valid_q, primed_q;

    assign accept        = in_valid & ~clear;
    // Lengths 0/1 would let a read hit the write still pending from the previous beat.
    assign shift_clamped = (shift_size < ADDR_W'(2)) ? ADDR_W'(2) : shift_size;
    assign len_eff       = load_pending_q ? shift_clamped : len_q;
    assign rd_addr       = wr_ptr_q - len_eff;
    assign prime_thresh  = FILL_W'(TAPS) * FILL_W'(len_eff);

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        len_d    = len_eff;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (clear) begin
            len_d    = shift_clamped;
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (in_valid) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pending_q <= 1'b1;
            len_q          <= ADDR_W'(2);
            wr_ptr_q       <= '0;
            fill_q         <= '0;
        end else begin
            load_pending_q <= 1'b0;
            len_q          <= len_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_q         <= fill_d;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_primed_q <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_primed_q <= (fill_q >= prime_thresh);
                s1_addr_q   <= wr_ptr_q;
                s1_data_q   <= in_data;
            end
        end
    end

    // RAM k+1 stores the tap-k word; it is written one cycle after accept, once that word is read out.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic [DATA_W-1:0] mem [2**ADDR_W];
        logic [DATA_W-1:0] rd_q;
        logic [DATA_W-1:0] wr_word;

        if (k == 0) begin : g_first
            assign wr_word = s1_data_q;
        end else begin : g_chain
            assign wr_word = rd_all[(k-1)*DATA_W +: DATA_W];
        end

        // NOTE: storage is deliberately not reset; only control state is, so this maps onto block RAM.
        always_ff @(posedge system_clk) begin
            if (s1_valid_q) mem[s1_addr_q] <= wr_word;
            if (accept)     rd_q <= mem[rd_addr];
        end

        assign rd_all[k*DATA_W +: DATA_W] = rd_q;
    end

`ifdef LINE_BUF_ZERO_FILL_EN
    logic [TAPS-1:0] zero_d, s1_zero_q;

    always_comb begin
        zero_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            zero_d[k] = fill_q < (FILL_W'(k + 1) * FILL_W'(len_eff));
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n)      s1_zero_q <= '1;
        else if (accept) s1_zero_q <= zero_d;
    end
`endif

    always_comb begin
        out_d = '0;
        out_d[DATA_W-1:0] = s1_data_q;
        for (int k = 1; k <= TAPS; k++) begin
`ifdef LINE_BUF_ZERO_FILL_EN
            out_d[k*DATA_W +: DATA_W] = s1_zero_q[k-1] ? '0 : rd_all[(k-1)*DATA_W +: DATA_W];
`else
            out_d[k*DATA_W +: DATA_W] = rd_all[(k-1)*DATA_W +: DATA_W];
`endif
        end
    end

    // Output words only move on a real beat, so RAM read-port changes during stalls stay hidden.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            primed_q    <= 1'b0;
        end else if (clear) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            primed_q    <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_d;
                primed_q   <= s1_primed_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_ram_line_buffer_multi_tap.sv
// Scoreboard bench for ram_line_buffer_multi_tap: driver pushes expected taps, negedge monitor checks.
// Covers reset, basic stream, stalls, clear mid-stream, length clamp, pointer wrap and async reset.
module tb_ram_line_buffer_multi_tap;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int TAPS   = 2;
    localparam int OUT_W  = DATA_W * (TAPS + 1);

    logic              system_clk = 1'b0;
    logic              rst_n      = 1'b0;
    logic              clear      = 1'b0;
    logic [ADDR_W-1:0] shift_size = ADDR_W'(4);
    logic              in_valid   = 1'b0;
    logic [DATA_W-1:0] in_data    = '0;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              primed;

    ram_line_buffer_multi_tap #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAPS(TAPS)) dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .shift_size (shift_size),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .primed     (primed)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [OUT_W-1:0] mask;
        logic             primed;
        int               epoch;
        int               beat;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] hist[$];
    int                cur_len = 4;
    int                epoch   = 0;
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [OUT_W-1:0]  last_out = '0;
    logic              flush_pending = 1'b0;

    task automatic check(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp, input logic [OUT_W-1:0] mask);
        n_checks++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
        end
    endtask

    // Reference model: taps come straight from the history of accepted words since the last flush.
    task automatic push_expect(input logic [DATA_W-1:0] d);
        exp_t e;
        int   n;
        hist.push_back(d);
        n = hist.size() - 1;
        e.data = '0;
        e.mask = '0;
        for (int k = 0; k <= TAPS; k++) begin
            if (n - k * cur_len >= 0) begin
                e.data[k*DATA_W +: DATA_W] = hist[n - k * cur_len];
                e.mask[k*DATA_W +: DATA_W] = '1;
            end
        end
        e.primed = (n >= TAPS * cur_len);
        e.epoch  = epoch;
        e.beat   = n;
        sb.push_back(e);
    endtask

    task automatic beat(input logic v, input logic [DATA_W-1:0] d);
        @(posedge system_clk);
        #1;
        clear    = 1'b0;
        in_valid = v;
        in_data  = d;
        if (v) push_expect(d);
    endtask

    task automatic do_clear(input logic [ADDR_W-1:0] len, input logic v, input logic [DATA_W-1:0] d);
        @(posedge system_clk);
        #1;
        clear      = 1'b1;
        shift_size = len;
        in_valid   = v;
        in_data    = d;
        epoch++;
        hist.delete();
        cur_len = (len < 2) ? 2 : int'(len);
    endtask

    task automatic stream(input int count, input logic [DATA_W-1:0] base);
        for (int i = 0; i < count; i++) beat(1'b1, base + DATA_W'(i));
    endtask

    always @(negedge system_clk) begin
        if (!rst_n || flush_pending) begin
            while (sb.size() > 0 && sb[0].epoch != epoch) void'(sb.pop_front());
            check("flush out_valid", OUT_W'(out_valid), '0, '1);
            check("flush out_data", out_data, '0, '1);
            check("flush primed", OUT_W'(primed), '0, '1);
            last_out = '0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int k = 0; k <= TAPS; k++) begin
                    logic [OUT_W-1:0] m;
                    m = '0;
                    m[k*DATA_W +: DATA_W] = '1;
                    if ((e.mask & m) != '0)
                        check($sformatf("beat %0d slice %0d", e.beat, k), out_data, e.data, m);
                end
                check($sformatf("beat %0d primed", e.beat), OUT_W'(primed), OUT_W'(e.primed), '1);
            end
            last_out = out_data;
        end else begin
            check("hold out_data", out_data, last_out, '1);
        end
        flush_pending = clear && rst_n;
    end

    initial begin
        static logic stall_pat[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [DATA_W-1:0] cnt;
        int guard;

        // Reset with L=4, then the basic stream 1,2,3,...
        repeat (3) @(posedge system_clk);
        #2;
        rst_n   = 1'b1;
        cur_len = 4;
        @(negedge system_clk);
        check("reset out_valid", OUT_W'(out_valid), '0, '1);
        check("reset out_data", out_data, '0, '1);
        stream(20, 32'd1);
        repeat (3) beat(1'b0, '0);

        // Stalls with L=3: taps follow accepted beats, output held during gaps.
        do_clear(ADDR_W'(3), 1'b0, '0);
        cnt = 32'h0000_0100;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 7; i++) begin
                beat(stall_pat[i], cnt);
                if (stall_pat[i]) cnt++;
            end
        end
        stream(6, 32'h0000_0200);

        // Clear while in_valid=1: that beat is dropped and the new length 5 applies.
        do_clear(ADDR_W'(5), 1'b1, 32'hDEAD_BEEF);
        stream(20, 32'h0000_0300);

        // Length clamp: 0 and 1 both behave as 2; shift_size changes mid-stream are ignored.
        do_clear(ADDR_W'(0), 1'b0, '0);
        stream(6, 32'h0000_0400);
        shift_size = ADDR_W'(7);
        stream(6, 32'h0000_0410);
        do_clear(ADDR_W'(1), 1'b0, '0);
        stream(10, 32'h0000_0500);

        // Maximum length with pointer wrap.
        do_clear(ADDR_W'(1023), 1'b0, '0);
        stream(3000, 32'h0001_0000);

        // Async reset mid-stream, then restart the basic case.
        do_clear(ADDR_W'(4), 1'b0, '0);
        stream(10, 32'h0000_0700);
        @(posedge system_clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        epoch++;
        hist.delete();
        #1;
        check("async reset out_valid", OUT_W'(out_valid), '0, '1);
        check("async reset out_data", out_data, '0, '1);
        shift_size = ADDR_W'(4);
        cur_len    = 4;
        repeat (2) @(posedge system_clk);
        #2;
        rst_n = 1'b1;
        stream(16, 32'd1);
        repeat (4) beat(1'b0, '0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge system_clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d outstanding beats expected 0", sb.size());
        end
        @(negedge system_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
